// File: rtl/vfat_sbit_tx_pkg.sv
// vfat_sbit_tx_pkg: shared sizes, mode encodings, FSM states and the frame pattern builder
package vfat_sbit_tx_pkg;

    localparam int MXSBITS     = 64;
    localparam int LANES       = 8;
    localparam int SLOTS       = 8;
    localparam int SYNC_FRAMES = 16;

    localparam logic [1:0] MODE_EXT  = 2'd0;
    localparam logic [1:0] MODE_WALK = 2'd1;
    localparam logic [1:0] MODE_CNT  = 2'd2;
    localparam logic [1:0] MODE_ONES = 2'd3;

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    // Lane i slot k carries bit i*SLOTS+k, so replicating the counter byte puts it on every lane LSB first
    function automatic logic [MXSBITS-1:0] pattern(input logic [1:0] mode, input logic [7:0] cnt,
                                                   input logic [MXSBITS-1:0] ext);
        return mode == MODE_WALK ? MXSBITS'(1) << cnt[5:0] :
               mode == MODE_CNT  ? {LANES{cnt}} :
               mode == MODE_ONES ? '1 : ext;
    endfunction

endpackage

// File: rtl/vfat_sbit_tx_if.sv
// vfat_sbit_tx_if: control, pattern and serial output bundle of one emulated VFAT trigger unit
interface vfat_sbit_tx_if;
    import vfat_sbit_tx_pkg::*;

    logic               enable;
    logic [1:0]         mode;
    logic               mask;
    logic               inject_sof_err;
    logic [MXSBITS-1:0] sbits_in;
    logic               load;
    logic [LANES-1:0]   sbits_out;
    logic               start_of_frame;
    logic [7:0]         frame_cnt;
    logic               synced;

    modport master (
        output enable, mode, mask, inject_sof_err, sbits_in,
        input  load, sbits_out, start_of_frame, frame_cnt, synced
    );

    modport slave (
        input  enable, mode, mask, inject_sof_err, sbits_in,
        output load, sbits_out, start_of_frame, frame_cnt, synced
    );

endinterface

// File: rtl/vfat_sbit_tx_serializer.sv
// sbit_lane_serializer: 8-slot parallel-load shift register, LSB transmitted first
module sbit_lane_serializer
    import vfat_sbit_tx_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [SLOTS-1:0] din,
    output logic             dout
);

    logic [SLOTS-1:0] sr;

    // load a new frame slice, otherwise shift the next slot into the output bit
    always_ff @(posedge clock) sr <= reset || clear ? '0 : load ? din : sr >> 1;

    assign dout = sr[0];

endmodule

// File: rtl/vfat_sbit_tx.sv
// vfat_sbit_tx: serializes 64 S-bits onto 8 lanes plus start-of-frame with training and test patterns
module vfat_sbit_tx
    import vfat_sbit_tx_pkg::*;
(
    input logic           clock,
    input logic           reset,
    vfat_sbit_tx_if.slave bus
);

    state_t             state, state_next;
    logic [2:0]         slot;
    logic [7:0]         fc;
    logic               pending;
    logic               delay_sof;
    logic               dly_now;
    logic               active;
    logic               load_q;
    logic               sof_q;
    logic               synced_q;
    logic [7:0]         frame_cnt_q;
    logic [MXSBITS-1:0] word;
    logic [LANES-1:0]   lanes;

    // Dropping enable silences everything on the very next cycle, not only after the state update
    assign active  = state != IDLE && bus.enable;
    // The delay decision for a frame is taken at its slot 0 and held for the rest of it
    assign dly_now = slot == 3'd0 ? pending : delay_sof;
    // fc already counts the frame about to start, so the word and its frame number line up
    assign word    = state == RUN && !bus.mask ? pattern(bus.mode, fc, bus.sbits_in) : '0;

    // state register
    always_ff @(posedge clock) state <= reset ? IDLE : state_next;

    // next state: leave SYNC only on the wrap that completes the last training frame
    always_comb begin
        state_next = state;
        if (!bus.enable)
            state_next = IDLE;
        else if (state == IDLE)
            state_next = SYNC;
        else if (state == SYNC && slot == 3'(SLOTS - 1) && fc == 8'(SYNC_FRAMES - 1))
            state_next = RUN;
    end

    // slot and frame counters plus the coalescing start-of-frame error flag
    always_ff @(posedge clock) begin
        if (reset || !active) begin
            slot      <= '0;
            fc        <= '0;
            pending   <= 1'b0;
            delay_sof <= 1'b0;
        end else begin
            slot      <= slot + 3'd1;
            fc        <= slot == 3'(SLOTS - 1) ? fc + 8'd1 : fc;
            pending   <= bus.inject_sof_err || (pending && slot != 3'd0);
            delay_sof <= dly_now;
        end
    end

    // output registers, one cycle behind the slot counter
    always_ff @(posedge clock) begin
        if (reset || !active) begin
            load_q      <= 1'b0;
            sof_q       <= 1'b0;
            synced_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            load_q      <= slot == 3'(SLOTS - 1);
            sof_q       <= dly_now ? slot == 3'd1 : slot == 3'd0;
            synced_q    <= state == RUN;
            frame_cnt_q <= fc;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbit_lane_serializer u_ser (
            .clock (clock),
            .reset (reset),
            .clear (!active),
            .load  (load_q),
            .din   (word[i*SLOTS +: SLOTS]),
            .dout  (lanes[i])
        );
    end

    assign bus.load           = load_q;
    assign bus.sbits_out      = lanes;
    assign bus.start_of_frame = sof_q;
    assign bus.frame_cnt      = frame_cnt_q;
    assign bus.synced         = synced_q;

endmodule

// File: tb/tb_vfat_sbit_tx.sv
// tb_vfat_sbit_tx: randomized stimulus checked every cycle against a frame-level reference model
module tb_vfat_sbit_tx;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    vfat_sbit_tx_if bus();

    vfat_sbit_tx dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model of what is on the wires this cycle
    int          ph    = 0;
    int          k     = 0;
    int          fnum  = 0;
    int          total = 0;
    bit          run   = 1'b0;
    bit          dly   = 1'b0;
    bit          pend  = 1'b0;
    logic [63:0] cur   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_word(input int mode, input int fn, input logic [63:0] ext);
        logic [63:0] w = '0;
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < 8; s++) begin
                int b = i * 8 + s;
                case (mode)
                    0:       w[b] = ext[b];
                    1:       w[b] = (b == fn % 64);
                    2:       w[b] = 1'((fn >> s) & 1);
                    default: w[b] = 1'b1;
                endcase
            end
        end
        return w;
    endfunction

    task automatic compare();
        logic [7:0] el = '0;
        bool_on: begin end
        if (ph == 2)
            for (int i = 0; i < 8; i++) el[i] = cur[i * 8 + k];
        check("sof",       bus.start_of_frame, 64'(ph == 2 && (dly ? k == 1 : k == 0)));
        check("load",      bus.load,           64'(ph == 2 && k == 7));
        check("lanes",     bus.sbits_out,      64'(el));
        check("frame_cnt", bus.frame_cnt,      64'(ph == 2 ? fnum : 0));
        check("synced",    bus.synced,         64'(ph == 2 && run));
    endtask

    task automatic cycle(input bit rst, input bit en, input int mode, input bit msk, input bit inj,
                         input logic [63:0] sb);
        reset              = rst;
        bus.enable         = en;
        bus.mode           = 2'(mode);
        bus.mask           = msk;
        bus.inject_sof_err = inj;
        bus.sbits_in       = sb;
        if (rst || !en) begin
            ph   = 0;
            pend = 1'b0;
        end else if (ph == 0) begin
            ph = 1;
        end else if (ph == 1) begin
            ph    = 2;
            k     = 0;
            fnum  = 0;
            total = 0;
            run   = 1'b0;
            cur   = '0;
            dly   = 1'b0;
            pend  = inj;
        end else if (k < 7) begin
            k++;
            pend = pend | inj;
        end else begin
            k     = 0;
            total++;
            fnum  = (fnum + 1) % 256;
            run   = total >= 16;
            cur   = run && !msk ? ref_word(mode, fnum, sb) : '0;
            dly   = pend;
            pend  = inj;
        end
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic stim(input int n, input int mode_sel, input int mask_pct, input int inj_pct, input bit rand_sb);
        for (int c = 0; c < n; c++) begin
            int          mode = mode_sel < 0 ? int'($urandom_range(0, 3)) : mode_sel;
            bit          msk  = $urandom_range(0, 99) < mask_pct;
            bit          inj  = ph == 2 && k >= 1 && k <= 5 && $urandom_range(0, 99) < inj_pct;
            logic [63:0] sb   = rand_sb ? {$urandom, $urandom} : 64'h0123_4567_89AB_CDEF;
            cycle(1'b0, 1'b1, mode, msk, inj, sb);
        end
    endtask

    task automatic stop(input int n, input bit use_reset);
        for (int c = 0; c < n; c++)
            cycle(use_reset, !use_reset, int'($urandom_range(0, 3)), 1'b0, 1'b1, {$urandom, $urandom});
    endtask

    initial begin
        bus.enable         = 1'b0;
        bus.mode           = 2'd0;
        bus.mask           = 1'b0;
        bus.inject_sof_err = 1'b0;
        bus.sbits_in       = '0;
        stop(3, 1'b1);
        stop(2, 1'b0);
        stim(20 * 8 + 2, 0, 0, 0, 1'b0);
        stim(70 * 8, 1, 0, 0, 1'b1);
        stim(260 * 8, 2, 0, 0, 1'b1);
        stim(30 * 8, 3, 0, 25, 1'b1);
        stim(20 * 8, 3, 30, 0, 1'b1);
        stim(100 * 8, -1, 20, 10, 1'b1);
        for (int r = 0; r < 12; r++) begin
            stim(int'($urandom_range(1, 220)), -1, 20, 10, 1'b1);
            stop(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end
        stim(20 * 8, -1, 10, 10, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
